// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Fetch control states: issue a request, wait for its data, or discard stale data.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam int unsigned PC_INC      = 4;
  localparam int unsigned DEF_ADDR_W  = 64;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_DEPTH   = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, instruction} entries for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_INSTR_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over push and pop; a push into a full queue is only taken alongside a pop.
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem read, PC sequencing/redirect, decode queue.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_cur,
  output logic [ADDR_W-1:0]  pc_newpc,
  output logic               pc_w,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int unsigned ENT_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  state_t             state;
  state_t             next_state;
  logic [ADDR_W-1:0]  req_pc;
  logic [CNT_W-1:0]   count;
  logic [ENT_W-1:0]   head;
  logic               space;
  logic               req_valid_c;
  logic               pc_w_c;
  logic [ADDR_W-1:0]  newpc_c;
  logic               push_c;
  logic               flush_c;
  logic               load_req_c;
  logic               pop_c;

  // With at most one read in flight, any free entry now is still free when data returns.
  assign space = (count < CNT_W'(DEPTH));

  // State and request-PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_FETCH;
      req_pc <= '0;
    end else begin
      state <= next_state;
      if (load_req_c) req_pc <= pc_cur;
    end
  end

  // Next-state and control decode; redirect overrides everything else.
  always_comb begin
    next_state  = state;
    req_valid_c = 1'b0;
    pc_w_c      = 1'b0;
    newpc_c     = pc_cur;
    push_c      = 1'b0;
    flush_c     = 1'b0;
    load_req_c  = 1'b0;
    if (redirect_valid) begin
      pc_w_c  = 1'b1;
      newpc_c = redirect_pc;
      flush_c = 1'b1;
      unique case (state)
        ST_FETCH: next_state = ST_FETCH;
        // A response in the redirect cycle closes the outstanding read; otherwise drop it later.
        ST_WAIT:  next_state = imem_rsp_valid ? ST_FETCH : ST_DROP;
        ST_DROP:  next_state = imem_rsp_valid ? ST_FETCH : ST_DROP;
        default:  next_state = ST_FETCH;
      endcase
    end else begin
      unique case (state)
        ST_FETCH: begin
          req_valid_c = space;
          if (space && imem_req_ready) begin
            pc_w_c     = 1'b1;
            newpc_c    = pc_cur + ADDR_W'(PC_INC);
            load_req_c = 1'b1;
            next_state = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            push_c     = 1'b1;
            next_state = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid) next_state = ST_FETCH;
        end
        default: next_state = ST_FETCH;
      endcase
    end
  end

  // Decode queue of {pc, instruction} entries.
  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data ({req_pc, imem_rsp_data}),
    .pop       (pop_c),
    .flush     (flush_c),
    .head      (head),
    .count     (count)
  );

  // Outputs are combinational and forced quiet while reset is asserted.
  assign imem_req_valid = !rst && req_valid_c;
  assign imem_req_addr  = pc_cur;
  assign pc_w           = !rst && pc_w_c;
  assign pc_newpc       = rst ? pc_cur : newpc_c;
  assign instr_valid    = !rst && (count != '0) && !redirect_valid;
  assign pop_c          = instr_valid && instr_ready;
  assign instr_pc       = head[ENT_W-1:INSTR_W];
  assign instr_data     = head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a queue-based behavioural model.
module tb_instr_fetch;

  localparam int unsigned AW    = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_cur;
  logic [AW-1:0] pc_newpc;
  logic          pc_w;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_cur         (pc_cur),
    .pc_newpc       (pc_newpc),
    .pc_w           (pc_w),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] d;
  } ent_t;

  // Scoreboard counters
  int n_vec = 0;
  int n_bad = 0;

  // Stimulus knobs
  int p_ready, p_iready, p_redir, lat_lo, lat_hi, redir_mode;
  logic [AW-1:0] redir_tgt;
  bit fired;

  // Model: decode queue contents, read status (0 none, 1 live, 2 stale), pc of live read
  ent_t mq[$];
  int kind;
  logic [AW-1:0] req_pc_m;

  // Memory: pending responses with due cycle
  int due_q[$];
  logic [AW-1:0] maddr_q[$];
  int cyc = 0;

  // Observations of the DUT used by literal checks
  logic [AW-1:0] acc[$];
  logic [AW-1:0] newpcs[$];
  logic [AW-1:0] pops[$];
  logic last_pcw, last_rv, last_iv;
  logic [AW-1:0] last_np, last_addr;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a[31:0] * 32'd2654435761) ^ a[63:32] ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    logic redir, rsp, e_req, e_iv, e_pcw, accept;
    logic [AW-1:0] e_np;
    int lat, due;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < p_ready);
    instr_ready    = ($urandom_range(99) < p_iready);
    rsp = 1'b0;
    imem_rsp_data = $urandom;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      rsp = 1'b1;
      imem_rsp_data = mem_word(maddr_q[0]);
      void'(due_q.pop_front());
      void'(maddr_q.pop_front());
    end
    imem_rsp_valid = rsp;
    redir = 1'b0;
    case (redir_mode)
      1: redir = !fired && kind == 1 && mq.size() == 3 && rsp;
      2: redir = !fired && kind == 1;
      default: redir = ($urandom_range(99) < p_redir);
    endcase
    if (redir && redir_mode != 0) fired = 1'b1;
    redirect_valid = redir;
    redirect_pc = (redir_mode == 0) ? ({$urandom, $urandom} & ~64'h3) : redir_tgt;
    #1;
    e_req = (kind == 0) && (mq.size() < DEPTH) && !redir;
    e_iv  = (mq.size() != 0) && !redir;
    accept = e_req && imem_req_ready;
    e_pcw = redir || accept;
    e_np  = redir ? redirect_pc : (accept ? pc_cur + 64'd4 : pc_cur);
    chk("req_valid", 64'(imem_req_valid), 64'(e_req));
    chk("req_addr", imem_req_addr, pc_cur);
    chk("pc_w", 64'(pc_w), 64'(e_pcw));
    chk("pc_newpc", pc_newpc, e_np);
    chk("instr_valid", 64'(instr_valid), 64'(e_iv));
    if (e_iv) begin
      chk("instr_pc", instr_pc, mq[0].pc);
      chk("instr_data", 64'(instr_data), 64'(mq[0].d));
    end
    if (imem_req_valid && imem_req_ready) acc.push_back(imem_req_addr);
    if (pc_w) newpcs.push_back(pc_newpc);
    if (instr_valid && instr_ready) pops.push_back(instr_pc);
    last_pcw = pc_w; last_np = pc_newpc; last_rv = imem_req_valid;
    last_addr = imem_req_addr; last_iv = instr_valid;
    if (redir) begin
      mq.delete();
      kind = (kind != 0 && !rsp) ? 2 : 0;
    end else begin
      if (e_iv && instr_ready) void'(mq.pop_front());
      if (kind == 1 && rsp) begin
        mq.push_back('{req_pc_m, imem_rsp_data});
        kind = 0;
      end else if (kind == 2 && rsp) begin
        kind = 0;
      end
      if (accept) begin
        kind = 1;
        req_pc_m = pc_cur;
        lat = $urandom_range(lat_hi, lat_lo);
        due = cyc + lat;
        if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
        due_q.push_back(due);
        maddr_q.push_back(pc_cur);
      end
    end
    @(posedge clk);
    #1;
    pc_cur = e_np;
    cyc++;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must go quiet without an edge.
  task automatic do_reset_mid();
    @(negedge clk);
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_pc_w", 64'(pc_w), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_pc_newpc", pc_newpc, pc_cur);
    mq.delete();
    kind = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Let outstanding memory reads complete without issuing new ones.
  task automatic drain();
    int sv;
    sv = p_ready;
    p_ready = 0;
    for (int i = 0; i < 12 && due_q.size() != 0; i++) step();
    chk("mem_drain", 64'(due_q.size()), 64'd0);
    p_ready = sv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pc_cur = 64'h1000;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    kind = 0; req_pc_m = '0; fired = 1'b0;
    p_redir = 0; redir_mode = 0; redir_tgt = '0;
    #2;
    chk("reset_req_valid", 64'(imem_req_valid), 64'd0);
    chk("reset_pc_w", 64'(pc_w), 64'd0);
    chk("reset_instr_valid", 64'(instr_valid), 64'd0);
    chk("reset_pc_newpc", pc_newpc, 64'h1000);
    chk("reset_req_addr", imem_req_addr, 64'h1000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch with 1-cycle memory and an always-ready decoder
    p_ready = 100; p_iready = 100; lat_lo = 1; lat_hi = 1;
    acc.delete(); newpcs.delete(); pops.delete();
    for (int i = 0; i < 10; i++) step();
    chk("seq_count", 64'(acc.size() >= 3 && pops.size() >= 3 && newpcs.size() >= 3), 64'd1);
    if (acc.size() >= 3 && pops.size() >= 3 && newpcs.size() >= 3) begin
      chk("seq_req0", acc[0], 64'h1000);
      chk("seq_req1", acc[1], 64'h1004);
      chk("seq_req2", acc[2], 64'h1008);
      chk("seq_np0", newpcs[0], 64'h1004);
      chk("seq_np2", newpcs[2], 64'h100C);
      chk("seq_pop0", pops[0], 64'h1000);
      chk("seq_pop2", pops[2], 64'h1008);
    end

    // Back-pressured decoder: queue fills, then one pop allows exactly one more request
    drain(); do_reset_mid();
    p_iready = 0;
    acc.delete();
    for (int i = 0; i < 20; i++) step();
    chk("full_reqs", 64'(acc.size()), 64'd4);
    chk("full_req_valid", 64'(last_rv), 64'd0);
    p_iready = 100; step(); p_iready = 0;
    acc.delete();
    for (int i = 0; i < 8; i++) step();
    chk("refill_reqs", 64'(acc.size()), 64'd1);

    // Redirect while waiting: pending data dropped, next fetch from the target
    drain(); do_reset_mid();
    p_iready = 100; lat_lo = 3; lat_hi = 3;
    redir_mode = 2; redir_tgt = 64'h2000; fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) step();
    chk("wait_redir_fired", 64'(fired), 64'd1);
    chk("wait_redir_pc_w", 64'(last_pcw), 64'd1);
    chk("wait_redir_newpc", last_np, 64'h2000);
    redir_mode = 0;
    acc.delete();
    for (int i = 0; i < 20 && acc.size() == 0; i++) step();
    chk("wait_redir_nreq", 64'(acc.size() > 0), 64'd1);
    if (acc.size() > 0) chk("wait_redir_addr", acc[0], 64'h2000);

    // Redirect coinciding with a response while three entries are queued
    drain(); do_reset_mid();
    p_iready = 0; lat_lo = 1; lat_hi = 1;
    redir_mode = 1; redir_tgt = 64'h3000; fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) step();
    chk("rsp_redir_fired", 64'(fired), 64'd1);
    redir_mode = 0;
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("rsp_redir_empty", 64'(instr_valid), 64'd0);
    chk("rsp_redir_fetch", 64'(imem_req_valid), 64'd1);

    // Memory stalls: request held stable, no PC write
    drain(); do_reset_mid();
    p_ready = 0; p_iready = 100;
    step();
    begin
      logic [AW-1:0] a0;
      a0 = last_addr;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        chk("stall_req_valid", 64'(last_rv), 64'd1);
        chk("stall_addr", last_addr, a0);
        chk("stall_pc_w", 64'(last_pcw), 64'd0);
      end
    end

    // Reset while a read is outstanding with two entries queued; stale data must be ignored
    p_ready = 100; p_iready = 0; lat_lo = 3; lat_hi = 3;
    do_reset_mid();
    for (int i = 0; i < 40 && !(kind == 1 && mq.size() == 2); i++) step();
    chk("midwait_reached", 64'(kind == 1 && mq.size() == 2), 64'd1);
    do_reset_mid();
    drain();
    chk("stale_ignored", 64'(last_iv), 64'd0);

    // Randomized traffic with occasional redirects and resets
    p_ready = 70; p_iready = 60; p_redir = 6; lat_lo = 1; lat_hi = 4;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 600; i++) step();
      do_reset_mid();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
